collision_event_handler: RTL and testbench
==========================================

Name: collision_event_handler

Overview:
- Consumes the per-pixel collision strobes produced by the game controller and turns them into one clean event per frame.
- Latches ("sticky") every collision seen during a frame, then acts on the latched set at the next startOfFrame. It issues single-cycle kill pulses to the rocket/alien/player objects and tracks lives, score and aliens remaining.
- Runs the game-level state machine (idle/play/hit-freeze/game-over/win) that gates object movement.

Parameters:
LIVES_INIT, 3, lives loaded at reset/start; legal range 1..3.
ALIEN_COUNT, 40, aliens at start; legal range 1..63.
ALIEN_POINTS, 10, score added per alien kill.
SCORE_W, 14, score width.
HIT_FREEZE_FRAMES, 60, frames the game is frozen after a non-fatal player hit; legal range 1..63.

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-cycle pulse per frame
startGame  in  1  one-cycle start request (debounced key)
alienHit  in  1  player rocket overlaps alien, per pixel
playerHitByAlienPulse  in  1  alien overlaps player, rising-edge pulse
playerHitByRocket  in  3  alien rocket i overlaps player
p_rocketsCollision  in  1  player rocket overlaps an alien rocket
a_rocketsCollision  in  3  alien rocket i overlaps the player rocket
aliensReachedBorder  in  1  alien pixel below the bottom line
killPlayerRocket  out  1  one-cycle pulse: remove player rocket
killAlienRockets  out  3  one-cycle pulse per alien rocket to remove
alienKilledPulse  out  1  one-cycle pulse: one alien destroyed
playerDiedPulse  out  1  one-cycle pulse: player lost a life
lives  out  2  lives remaining
score  out  SCORE_W  current score
aliensLeft  out  6  aliens remaining
gameState  out  3  IDLE=0, PLAY=1, HIT=2, GAME_OVER=3, WIN=4
freeze  out  1  1 = movement of all objects disabled

Behaviour:
- Interface: reset resetN, asynchronous, active-low; clock clk. All state changes on posedge clk.
- Reset values:
  - State: gameState=IDLE, freeze=1.
  - Counters: lives=LIVES_INIT, aliensLeft=ALIEN_COUNT, score=0.
  - Pulse outputs and sticky flags: 0.
- Sticky flags: fAlien, fPlayer, fBorder, fPRocket, fARocket[2:0]. Each is set by the OR of its inputs in any cycle:
  - fPlayer = playerHitByAlienPulse | (|playerHitByRocket)
  - fPRocket = alienHit | p_rocketsCollision
  - fARocket[i] = playerHitByRocket[i] | a_rocketsCollision[i]
- Evaluation at startOfFrame:
  - All decisions use the flag values held before the SOF cycle.
  - Flags are cleared in the SOF cycle; an input asserted in the SOF cycle sets the new frame's flags.
  - Outputs update in the cycle after SOF (latency 1). Every pulse output is high for exactly one clk.
- PLAY, evaluated at SOF:
  - killPlayerRocket=fPRocket; killAlienRockets=fARocket.
  - Priority 1: fBorder -> lives=0, playerDiedPulse, GAME_OVER.
  - Priority 2: fPlayer -> playerDiedPulse, lives-1. If the result is 0 -> GAME_OVER; else HIT and load the freeze counter with HIT_FREEZE_FRAMES.
  - Independently: fAlien with aliensLeft>0 -> alienKilledPulse, aliensLeft-1, score+=ALIEN_POINTS. Score saturates at 2^SCORE_W-1; at most one kill per frame.
  - aliensLeft reaching 0 in a frame with no player death -> WIN. If the player died in the same frame, the death transition wins.
- HIT:
  - freeze=1; flags are still cleared each SOF, but no kills, pulses or score changes.
  - Freeze counter decrements per SOF; the SOF that sees it at 1 returns to PLAY.
- IDLE, GAME_OVER, WIN:
  - freeze=1; collisions ignored.
  - startGame -> next cycle: lives=LIVES_INIT, score=0, aliensLeft=ALIEN_COUNT, flags cleared, PLAY.
  - startGame in PLAY/HIT is ignored.
- freeze=0 only in PLAY.
- Reset mid-game (resetN low) immediately forces all reset values, including any pulse in flight.

Test Plan:
- Reset, then startGame -> gameState 0→1, lives=3, score=0, aliensLeft=40, freeze=0.
- PLAY: alienHit high for 5 cycles mid-frame -> at next SOF+1 exactly one alienKilledPulse and one killPlayerRocket; score=10, aliensLeft=39.
- playerHitByRocket=3'b010 for 3 cycles -> killAlienRockets=3'b010 for one cycle, playerDiedPulse, lives=2, gameState=HIT. After 60 SOFs -> PLAY. Collisions injected during HIT produce no pulses.
- Same frame has fAlien with aliensLeft=1 and fPlayer with lives=1 -> aliensLeft=0, score+10, lives=0, gameState=GAME_OVER (not WIN).
- aliensReachedBorder for one cycle with lives=3 -> lives=0, GAME_OVER. Then startGame -> PLAY with full reload. alienHit asserted exactly on the SOF cycle counts in the following frame.
- resetN asserted while in HIT with pulses pending -> all outputs at reset values asynchronously; score=0, gameState=IDLE.

Source files
------------

// File: rtl/collision_event_handler_if.sv
// Collision strobes from the game controller and the per-frame event/status bus back to it.
// Single-cycle pulses and level status only; there is no flow control in either direction.
interface collision_event_handler_if #(
  parameter int SCORE_W = 14
);
  logic               startOfFrame;
  logic               startGame;
  logic               alienHit;
  logic               playerHitByAlienPulse;
  logic [2:0]         playerHitByRocket;
  logic               p_rocketsCollision;
  logic [2:0]         a_rocketsCollision;
  logic               aliensReachedBorder;
  logic               killPlayerRocket;
  logic [2:0]         killAlienRockets;
  logic               alienKilledPulse;
  logic               playerDiedPulse;
  logic [1:0]         lives;
  logic [SCORE_W-1:0] score;
  logic [5:0]         aliensLeft;
  logic [2:0]         gameState;
  logic               freeze;

  modport master (
    output startOfFrame, startGame, alienHit, playerHitByAlienPulse, playerHitByRocket,
           p_rocketsCollision, a_rocketsCollision, aliensReachedBorder,
    input  killPlayerRocket, killAlienRockets, alienKilledPulse, playerDiedPulse,
           lives, score, aliensLeft, gameState, freeze
  );

  modport slave (
    input  startOfFrame, startGame, alienHit, playerHitByAlienPulse, playerHitByRocket,
           p_rocketsCollision, a_rocketsCollision, aliensReachedBorder,
    output killPlayerRocket, killAlienRockets, alienKilledPulse, playerDiedPulse,
           lives, score, aliensLeft, gameState, freeze
  );
endinterface

// File: rtl/collision_event_handler.sv
// Latches collisions per frame and resolves them at startOfFrame into kill pulses, lives/score and game state.
// Outputs update one cycle after startOfFrame; every pulse lasts one clk; no backpressure.
module collision_event_handler #(
  parameter int LIVES_INIT        = 3,
  parameter int ALIEN_COUNT       = 40,
  parameter int ALIEN_POINTS      = 10,
  parameter int SCORE_W           = 14,
  parameter int HIT_FREEZE_FRAMES = 60
) (
  input logic                      clk,
  input logic                      resetN,
  collision_event_handler_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PLAY = 3'd1,
    S_HIT  = 3'd2,
    S_OVER = 3'd3,
    S_WIN  = 3'd4
  } state_t;

  localparam logic [1:0]         LIVES_RELOAD  = 2'(LIVES_INIT);
  localparam logic [5:0]         ALIENS_RELOAD = 6'(ALIEN_COUNT);
  localparam logic [5:0]         HOLD_RELOAD   = 6'(HIT_FREEZE_FRAMES);
  localparam logic [SCORE_W:0]   POINTS        = (SCORE_W+1)'(ALIEN_POINTS);

  state_t             state;
  logic               freeze;
  logic [5:0]         hold_cnt;
  logic [1:0]         lives;
  logic [SCORE_W-1:0] score;
  logic [5:0]         aliens_left;
  logic               kill_procket, alien_killed, player_died;
  logic [2:0]         kill_arockets;
  logic               f_alien, f_player, f_border, f_procket;
  logic [2:0]         f_arocket;

  logic               in_player, in_procket, kill;
  logic [2:0]         in_arocket;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_next;

  assign in_player  = bus.playerHitByAlienPulse | (|bus.playerHitByRocket);
  assign in_procket = bus.alienHit | bus.p_rocketsCollision;
  assign in_arocket = bus.playerHitByRocket | bus.a_rocketsCollision;
  assign kill       = f_alien && (aliens_left != 6'd0);
  assign score_sum  = {1'b0, score} + POINTS;
  assign score_next = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state         <= S_IDLE;
      freeze        <= 1'b1;
      hold_cnt      <= 6'd0;
      lives         <= LIVES_RELOAD;
      score         <= '0;
      aliens_left   <= ALIENS_RELOAD;
      kill_procket  <= 1'b0;
      kill_arockets <= 3'b000;
      alien_killed  <= 1'b0;
      player_died   <= 1'b0;
      f_alien       <= 1'b0;
      f_player      <= 1'b0;
      f_border      <= 1'b0;
      f_procket     <= 1'b0;
      f_arocket     <= 3'b000;
    end else begin
      kill_procket  <= 1'b0;
      kill_arockets <= 3'b000;
      alien_killed  <= 1'b0;
      player_died   <= 1'b0;
      case (state)
        S_PLAY, S_HIT: begin
          // The SOF cycle starts a new frame: decisions below use the old flags.
          if (bus.startOfFrame) begin
            f_alien   <= bus.alienHit;
            f_player  <= in_player;
            f_border  <= bus.aliensReachedBorder;
            f_procket <= in_procket;
            f_arocket <= in_arocket;
          end else begin
            f_alien   <= f_alien | bus.alienHit;
            f_player  <= f_player | in_player;
            f_border  <= f_border | bus.aliensReachedBorder;
            f_procket <= f_procket | in_procket;
            f_arocket <= f_arocket | in_arocket;
          end
          if (bus.startOfFrame && state == S_PLAY) begin
            kill_procket  <= f_procket;
            kill_arockets <= f_arocket;
            if (kill) begin
              alien_killed <= 1'b1;
              aliens_left  <= aliens_left - 6'd1;
              score        <= score_next;
            end
            // A death outranks a simultaneous last-alien kill.
            if (f_border) begin
              lives       <= 2'd0;
              player_died <= 1'b1;
              state       <= S_OVER;
              freeze      <= 1'b1;
            end else if (f_player) begin
              lives       <= lives - 2'd1;
              player_died <= 1'b1;
              freeze      <= 1'b1;
              if (lives == 2'd1) begin
                state <= S_OVER;
              end else begin
                state    <= S_HIT;
                hold_cnt <= HOLD_RELOAD;
              end
            end else if (kill && aliens_left == 6'd1) begin
              state  <= S_WIN;
              freeze <= 1'b1;
            end
          end else if (bus.startOfFrame) begin
            if (hold_cnt == 6'd1) begin
              state  <= S_PLAY;
              freeze <= 1'b0;
            end
            hold_cnt <= hold_cnt - 6'd1;
          end
        end
        default: begin
          f_alien   <= 1'b0;
          f_player  <= 1'b0;
          f_border  <= 1'b0;
          f_procket <= 1'b0;
          f_arocket <= 3'b000;
          if (bus.startGame) begin
            lives       <= LIVES_RELOAD;
            score       <= '0;
            aliens_left <= ALIENS_RELOAD;
            state       <= S_PLAY;
            freeze      <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.gameState        = state;
  assign bus.freeze           = freeze;
  assign bus.lives            = lives;
  assign bus.score            = score;
  assign bus.aliensLeft       = aliens_left;
  assign bus.killPlayerRocket = kill_procket;
  assign bus.killAlienRockets = kill_arockets;
  assign bus.alienKilledPulse = alien_killed;
  assign bus.playerDiedPulse  = player_died;
endmodule

// File: tb/tb_collision_event_handler.sv
// Directed game scenarios plus randomized frames, checked every cycle against a frame-level game model.
module tb_collision_event_handler;
  localparam int IDLE = 0, PLAY = 1, HIT = 2, OVER = 3, WIN = 4;
  localparam int SCORE_MAX = 16383;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  int n_checks = 0;
  int n_errors = 0;

  collision_event_handler_if bus ();
  collision_event_handler dut (.clk(clk), .resetN(resetN), .bus(bus));

  always #5 clk = ~clk;

  // Frame-level model: hit counts per frame, resolved as game events at each SOF.
  int m_state, m_lives, m_score, m_aliens, m_frames_left;
  bit m_kpr, m_akp, m_pdp;
  bit [2:0] m_kar;
  int c_alien, c_player, c_border, c_prock;
  int c_arock[3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void clear_counts();
    c_alien = 0; c_player = 0; c_border = 0; c_prock = 0;
    for (int i = 0; i < 3; i++) c_arock[i] = 0;
  endfunction

  function automatic void model_reset();
    m_state = IDLE; m_lives = 3; m_score = 0; m_aliens = 40; m_frames_left = 0;
    m_kpr = 0; m_akp = 0; m_pdp = 0; m_kar = 3'b000;
    clear_counts();
  endfunction

  function automatic void resolve_frame();
    m_kpr = (c_prock > 0);
    for (int i = 0; i < 3; i++) m_kar[i] = (c_arock[i] > 0);
    if (c_alien > 0 && m_aliens > 0) begin
      m_akp = 1;
      m_aliens = m_aliens - 1;
      m_score = (m_score + 10 > SCORE_MAX) ? SCORE_MAX : m_score + 10;
    end
    if (c_border > 0) begin
      m_pdp = 1; m_lives = 0; m_state = OVER;
    end else if (c_player > 0) begin
      m_pdp = 1; m_lives = m_lives - 1;
      m_state = (m_lives == 0) ? OVER : HIT;
      m_frames_left = 60;
    end else if (m_akp && m_aliens == 0) begin
      m_state = WIN;
    end
  endfunction

  function automatic void model_cycle(input bit sof, st, ah, pha, input bit [2:0] phr,
                                      input bit prc, input bit [2:0] arc, input bit brd);
    m_kpr = 0; m_akp = 0; m_pdp = 0; m_kar = 3'b000;
    if (m_state == PLAY || m_state == HIT) begin
      if (sof) begin
        if (m_state == PLAY) resolve_frame();
        else begin
          m_frames_left = m_frames_left - 1;
          if (m_frames_left == 0) m_state = PLAY;
        end
        clear_counts();
      end
      c_alien  += int'(ah);
      c_player += int'(pha || phr != 3'b000);
      c_border += int'(brd);
      c_prock  += int'(ah || prc);
      for (int i = 0; i < 3; i++) c_arock[i] += int'(phr[i] || arc[i]);
    end else begin
      clear_counts();
      if (st) begin
        m_state = PLAY; m_lives = 3; m_score = 0; m_aliens = 40;
      end
    end
  endfunction

  task automatic check_all();
    check("gameState", bus.gameState, m_state);
    check("freeze", bus.freeze, (m_state == PLAY) ? 0 : 1);
    check("lives", bus.lives, m_lives);
    check("score", bus.score, m_score);
    check("aliensLeft", bus.aliensLeft, m_aliens);
    check("killPlayerRocket", bus.killPlayerRocket, m_kpr);
    check("killAlienRockets", bus.killAlienRockets, m_kar);
    check("alienKilledPulse", bus.alienKilledPulse, m_akp);
    check("playerDiedPulse", bus.playerDiedPulse, m_pdp);
  endtask

  task automatic step(input bit sof, st, ah, pha, input bit [2:0] phr,
                      input bit prc, input bit [2:0] arc, input bit brd);
    bus.startOfFrame = sof; bus.startGame = st; bus.alienHit = ah;
    bus.playerHitByAlienPulse = pha; bus.playerHitByRocket = phr;
    bus.p_rocketsCollision = prc; bus.a_rocketsCollision = arc; bus.aliensReachedBorder = brd;
    model_cycle(sof, st, ah, pha, phr, prc, arc, brd);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic quiet(); step(0, 0, 0, 0, 3'b000, 0, 3'b000, 0); endtask
  task automatic sof();   step(1, 0, 0, 0, 3'b000, 0, 3'b000, 0); endtask
  task automatic start(); step(0, 1, 0, 0, 3'b000, 0, 3'b000, 0); endtask
  task automatic alien(); step(0, 0, 1, 0, 3'b000, 0, 3'b000, 0); endtask

  task automatic async_reset();
    #1 resetN = 1'b0;
    model_reset();
    #1 check_all();
    check("rst_state", bus.gameState, IDLE);
    check("rst_score", bus.score, 0);
    check("rst_pulse", bus.playerDiedPulse, 0);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  initial begin
    bus.startOfFrame = 0; bus.startGame = 0; bus.alienHit = 0; bus.playerHitByAlienPulse = 0;
    bus.playerHitByRocket = 0; bus.p_rocketsCollision = 0; bus.a_rocketsCollision = 0;
    bus.aliensReachedBorder = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    check("reset_freeze", bus.freeze, 1);
    check("reset_aliens", bus.aliensLeft, 40);
    resetN = 1'b1;

    start();
    check("start_state", bus.gameState, PLAY);
    check("start_lives", bus.lives, 3);

    sof();
    repeat (5) alien();
    quiet();
    sof();
    check("kill_pulse", bus.alienKilledPulse, 1);
    check("kill_score", bus.score, 10);
    check("kill_aliens", bus.aliensLeft, 39);
    quiet();
    check("kill_once", bus.alienKilledPulse, 0);

    repeat (3) step(0, 0, 0, 0, 3'b010, 0, 3'b000, 0);
    sof();
    check("hit_rockets", bus.killAlienRockets, 3'b010);
    check("hit_lives", bus.lives, 2);
    check("hit_state", bus.gameState, HIT);
    for (int f = 1; f <= 60; f++) begin
      if (f < 60) begin
        step(0, 1, 1, 1, 3'b101, 1, 3'b011, 1);
        quiet();
      end
      sof();
      if (f == 59) check("hit_hold", bus.gameState, HIT);
    end
    check("hit_resume", bus.gameState, PLAY);

    for (int i = 0; i < 38; i++) begin alien(); sof(); end
    check("one_left", bus.aliensLeft, 1);
    step(0, 0, 0, 1, 3'b000, 0, 3'b000, 0);
    sof();
    for (int f = 0; f < 60; f++) begin quiet(); sof(); end
    check("last_life", bus.lives, 1);
    step(0, 0, 1, 1, 3'b000, 0, 3'b000, 0);
    sof();
    check("tie_aliens", bus.aliensLeft, 0);
    check("tie_score", bus.score, 400);
    check("tie_state", bus.gameState, OVER);

    start();
    step(0, 0, 0, 0, 3'b000, 0, 3'b000, 1);
    sof();
    check("border_lives", bus.lives, 0);
    check("border_state", bus.gameState, OVER);
    start();
    check("reload_aliens", bus.aliensLeft, 40);
    step(1, 0, 1, 0, 3'b000, 0, 3'b000, 0);
    check("sof_hit_wait", bus.alienKilledPulse, 0);
    quiet();
    sof();
    check("sof_hit_next", bus.alienKilledPulse, 1);

    repeat (1200) begin
      int len = $urandom_range(3, 10);
      if ($urandom_range(0, 399) == 0) async_reset();
      for (int c = 0; c < len; c++) begin
        step(c == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 299) == 0,
             {$urandom_range(0, 399) == 0, $urandom_range(0, 399) == 0, $urandom_range(0, 399) == 0},
             $urandom_range(0, 19) == 0,
             {$urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0},
             $urandom_range(0, 599) == 0);
      end
    end

    async_reset();
    start();
    step(0, 0, 0, 0, 3'b001, 0, 3'b000, 0);
    sof();
    check("pend_pulse", bus.playerDiedPulse, 1);
    async_reset();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
